// File: rtl/prng_stream_checker.sv
// Receive-side checker for a 16-bit LFSR PRNG stream (taps 15,14,12,3, shift left, feedback
// into bit 0). It seeds its local copy of the generator from the serial stream, verifies a run
// of predictions before declaring lock, then flywheels on its own predictions so isolated bit
// errors are counted without corrupting the local state.
// Optional feature: define PRNG_CHK_BITCNT_EN to add the bit_cnt output (bits checked in lock).
module prng_stream_checker #(
  parameter int unsigned LOCK_COUNT  = 32,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             mismatch,
  output logic             lost,
  output logic [ERR_W-1:0] err_cnt
`ifdef PRNG_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  localparam int unsigned RunW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MissW = $clog2(LOSS_THRESH + 1);
  // Counter values at which the current valid bit completes the run / the miss streak.
  localparam logic [RunW-1:0]  RunLast  = RunW'(LOCK_COUNT - 1);
  localparam logic [MissW-1:0] MissLast = MissW'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {StSeed, StVerify, StLocked} state_e;

  state_e           state_q, state_d;
  logic [15:0]      s_q, s_d;
  logic [3:0]       fill_q, fill_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [MissW-1:0] miss_q, miss_d;
  logic             mismatch_q, mismatch_d;
  logic             lost_q, lost_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pred;
  logic [15:0]      s_rx;

  assign pred = s_q[15] ^ s_q[14] ^ s_q[12] ^ s_q[3];
  assign s_rx = {s_q[14:0], bit_in};

  // Next-state: sequencing of seed / verify / locked and the error bookkeeping.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    fill_d     = fill_q;
    run_d      = run_q;
    miss_d     = miss_q;
    mismatch_d = 1'b0;
    lost_d     = lost_q;
    err_d      = err_q;

    if (bit_valid) begin
      unique case (state_q)
        StSeed: begin
          s_d    = s_rx;
          fill_d = fill_q + 4'd1;
          if (fill_q == 4'd15) begin
            fill_d = 4'd0;
            // An all-zero seed would lock the LFSR at zero forever; keep seeding instead.
            if (s_rx != 16'd0) begin
              state_d = StVerify;
              run_d   = '0;
            end
          end
        end
        StVerify: begin
          s_d = s_rx;
          if (bit_in == pred) begin
            run_d = run_q + 1'b1;
            if (run_q == RunLast) begin
              state_d = StLocked;
              run_d   = '0;
              miss_d  = '0;
            end
          end else begin
            mismatch_d = 1'b1;
            run_d      = '0;
            fill_d     = 4'd0;
            state_d    = StSeed;
          end
        end
        StLocked: begin
          // Flywheel: advance on the prediction so a bad bit does not poison the state.
          s_d = {s_q[14:0], pred};
          if (bit_in != pred) begin
            mismatch_d = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
            miss_d = miss_q + 1'b1;
            if (miss_q == MissLast) begin
              state_d = StSeed;
              fill_d  = 4'd0;
              miss_d  = '0;
              lost_d  = 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d = StSeed;
          fill_d  = 4'd0;
        end
      endcase
    end

    // Clear has priority over any simultaneous count or loss event.
    if (clr_cnt) begin
      err_d  = '0;
      lost_d = 1'b0;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSeed;
      s_q        <= 16'd0;
      fill_q     <= 4'd0;
      run_q      <= '0;
      miss_q     <= '0;
      mismatch_q <= 1'b0;
      lost_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      fill_q     <= fill_d;
      run_q      <= run_d;
      miss_q     <= miss_d;
      mismatch_q <= mismatch_d;
      lost_q     <= lost_d;
      err_q      <= err_d;
    end
  end

  assign locked   = (state_q == StLocked);
  assign mismatch = mismatch_q;
  assign lost     = lost_q;
  assign err_cnt  = err_q;

`ifdef PRNG_CHK_BITCNT_EN
  logic [31:0] bit_cnt_q;

  // Count every valid bit checked while locked; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= 32'd0;
    end else if (clr_cnt) begin
      bit_cnt_q <= 32'd0;
    end else if (bit_valid && (state_q == StLocked)) begin
      bit_cnt_q <= bit_cnt_q + 32'd1;
    end
  end

  assign bit_cnt = bit_cnt_q;
`else
  // No checked-bit counter in this build.
`endif

endmodule
